mem_io_bridge: RTL

Unified instruction/data memory plus memory-mapped GPIO for the multicycle MIPS core. It sits between the datapath and the control unit. It selects the address from PC or ALU result (I_or_D), reads and writes a word RAM, and holds the Instruction Register (IR) and the Memory Data Register (MDR). It supplies Op/Funct to the control unit and synchronises GPIO input.

---
 rtl/mem_io_bridge.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_io_bridge.sv
// Unified instruction/data memory, IR/MDR holding registers and memory-mapped GPIO for the multicycle MIPS core.
// Latency: reads are combinational and land in IR/MDR on the next rising edge; gpio_in reaches a read 2 edges after a change.
// Backpressure: none; every access completes in one cycle and writes to unmapped or read-only addresses are dropped.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   i_or_d          - address select (0 = pc, 1 = alu_out)
//   mem_write       - store wr_data to the selected address
//   ir_write        - load IR from the current read data
//   pc, alu_out     - byte addresses; bits [1:0] are ignored
//   wr_data         - store data
//   gpio_in         - asynchronous external inputs
//   instr/op/funct  - IR contents and its opcode/function fields
//   mem_data        - MDR contents
//   gpio_out        - output register
//   bad_addr        - sticky flag for an access to an unmapped address
module mem_io_bridge #(
    parameter int          DEPTH         = 256,
    parameter logic [31:0] RAM_BASE      = 32'h0040_0000,
    parameter logic [31:0] GPIO_OUT_ADDR = 32'h1001_0024,
    parameter logic [31:0] GPIO_IN_ADDR  = 32'h1001_0028,
    parameter int          GPIO_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_or_d,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       wr_data,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [31:0]       mem_data,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              bad_addr
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]       ram_q [DEPTH];

    logic [31:0]       instr_q,     instr_d;
    logic [31:0]       mdr_q,       mdr_d;
    logic [GPIO_W-1:0] gpio_out_q,  gpio_out_d;
    logic [GPIO_W-1:0] sync1_q,     sync1_d;
    logic [GPIO_W-1:0] gpio_sync_q, gpio_sync_d;
    logic              bad_addr_q,  bad_addr_d;

    logic [31:0]       addr;
    logic [31:0]       ram_off;
    logic [AW-1:0]     ram_idx;
    logic              ram_hit;
    logic              gout_hit;
    logic              gin_hit;
    logic              unmapped;
    logic              ram_we;
    logic [31:0]       rd_data;

    // Address decode. RAM_BASE is word aligned, so comparing the full byte
    // offset against the RAM size gives the same answer as ignoring addr[1:0].
    // The lower-bound test keeps addresses below RAM_BASE from wrapping in.
    always_comb begin
        addr     = i_or_d ? alu_out : pc;
        ram_off  = addr - RAM_BASE;
        ram_hit  = (addr >= RAM_BASE) && (ram_off < RAM_BYTES);
        ram_idx  = ram_off[AW+1:2];
        gout_hit = (addr[31:2] == GPIO_OUT_ADDR[31:2]);
        gin_hit  = (addr[31:2] == GPIO_IN_ADDR[31:2]);
        unmapped = !(ram_hit || gout_hit || gin_hit);
        ram_we   = mem_write && ram_hit;
    end

    always_comb begin
        rd_data = 32'h0;
        if (ram_hit) begin
            rd_data = ram_q[ram_idx];
        end else if (gout_hit) begin
            rd_data = 32'(gpio_out_q);
        end else if (gin_hit) begin
            rd_data = 32'(gpio_sync_q);
        end
    end

    always_comb begin
        instr_d     = ir_write ? rd_data : instr_q;
        mdr_d       = rd_data;
        gpio_out_d  = (mem_write && gout_hit) ? wr_data[GPIO_W-1:0] : gpio_out_q;
        sync1_d     = gpio_in;
        gpio_sync_d = sync1_q;
        // Only cycles that really use the address count; the control FSM
        // parks on pc with i_or_d=0 and ir_write=0 while idle.
        bad_addr_d  = bad_addr_q || (unmapped && (mem_write || ir_write || i_or_d));
    end

    // The RAM shares the reset branch structure so that an edge seen while
    // reset is held low never commits a store; its contents are not cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q     <= 32'h0;
            mdr_q       <= 32'h0;
            gpio_out_q  <= '0;
            sync1_q     <= '0;
            gpio_sync_q <= '0;
            bad_addr_q  <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            mdr_q       <= mdr_d;
            gpio_out_q  <= gpio_out_d;
            sync1_q     <= sync1_d;
            gpio_sync_q <= gpio_sync_d;
            bad_addr_q  <= bad_addr_d;
            if (ram_we) begin
                ram_q[ram_idx] <= wr_data;
            end
        end
    end

    assign instr    = instr_q;
    assign op       = instr_q[31:26];
    assign funct    = instr_q[5:0];
    assign mem_data = mdr_q;
    assign gpio_out = gpio_out_q;
    assign bad_addr = bad_addr_q;

endmodule
